// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Shared constants and helpers for the 2-read / 1-write architectural
// register file.
//   RF_DATA_W    register width in bits
//   RF_NUM_REGS  number of architectural registers
//   RF_ADDR_W    register index width (clog2 of RF_NUM_REGS)
//   RF_RESET_VAL value every register takes while rst is high
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int unsigned RF_DATA_W   = 16;
    localparam int unsigned RF_NUM_REGS = 8;
    localparam int unsigned RF_ADDR_W   = 3;

    localparam logic [RF_DATA_W-1:0] RF_RESET_VAL = 16'h0000;

    // Index of a register as seen on the select buses.
    typedef logic [RF_ADDR_W-1:0] rfIdx_t;

    // Register contents.
    typedef logic [RF_DATA_W-1:0] rfWord_t;

    // One-hot write-enable decode: bit i is set only when en is high and
    // sel addresses register i. Exactly zero or one bit is ever set.
    function automatic logic [RF_NUM_REGS-1:0] decodeOneHot(
        input rfIdx_t sel,
        input logic   en
    );
        logic [RF_NUM_REGS-1:0] oneHot;
        oneHot = '0;
        for (int unsigned i = 0; i < RF_NUM_REGS; i++) begin
            oneHot[i] = en && (sel == rfIdx_t'(i));
        end
        return oneHot;
    endfunction

endpackage

// File: rtl/regfile_2r1w_if.sv
// ----------------------------------------------------------------------------
// regfile_2r1w_if
// Bundles the decode-stage read ports and the writeback-stage write port of
// the register file.
//   read1RegSel / read2RegSel  operand indices (decode stage)
//   read1Data   / read2Data    operand values, combinational
//   writeRegSel / writeData    result index and value (writeback stage)
//   writeEn                    write strobe, sampled at rising clk
//   err                        control inputs contain X/Z (simulation only)
// Modports:
//   master  the pipeline side (drives selects and write port)
//   slave   the register file itself
// ----------------------------------------------------------------------------
interface regfile_2r1w_if
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W
);

    logic [ADDR_W-1:0] read1RegSel;
    logic [ADDR_W-1:0] read2RegSel;
    logic [ADDR_W-1:0] writeRegSel;
    logic [DATA_W-1:0] writeData;
    logic              writeEn;
    logic [DATA_W-1:0] read1Data;
    logic [DATA_W-1:0] read2Data;
    logic              err;

    modport master (
        output read1RegSel,
        output read2RegSel,
        output writeRegSel,
        output writeData,
        output writeEn,
        input  read1Data,
        input  read2Data,
        input  err
    );

    modport slave (
        input  read1RegSel,
        input  read2RegSel,
        input  writeRegSel,
        input  writeData,
        input  writeEn,
        output read1Data,
        output read2Data,
        output err
    );

endinterface

// File: rtl/regfile_2r1w_word.sv
// ----------------------------------------------------------------------------
// rf_word
// One register of the register file: a DATA_W-wide flop bank with load
// enable and asynchronous active-high reset. Reset dominates a coincident
// load.
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset to RESET_VAL
//   inData   value loaded when writeEn is high at a rising clk
//   writeEn  load enable
//   outData  stored value
// ----------------------------------------------------------------------------
module rf_word
    import rf_pkg::*;
#(
    parameter int unsigned          DATA_W    = RF_DATA_W,
    parameter logic [DATA_W-1:0]    RESET_VAL = DATA_W'(RF_RESET_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] inData,
    input  logic              writeEn,
    output logic [DATA_W-1:0] outData
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outData <= RESET_VAL;
        end else if (writeEn) begin
            outData <= inData;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// ----------------------------------------------------------------------------
// regfile_2r1w
// Architectural register file: NUM_REGS x DATA_W, two combinational read
// ports and one synchronous write port. Every register, including r0, is
// writable.
// Ports:
//   clk  system clock; all state updates on rising edge
//   rst  asynchronous active-high reset; clears every register at once
//   bus  regfile_2r1w_if.slave: selects, write port, read data, err
// Configuration macro:
//   RF_BYPASS_EN  when defined, a read whose index matches an active write
//                 returns writeData in the same cycle (suppressed while rst
//                 is high). When undefined, reads always show stored values
//                 and a write becomes visible the cycle after its edge.
// ----------------------------------------------------------------------------
module regfile_2r1w
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    regfile_2r1w_if.slave     bus
);

    logic [NUM_REGS-1:0] wordEn;
    logic [DATA_W-1:0]   wordQ [NUM_REGS];
    logic [DATA_W-1:0]   read1Stored;
    logic [DATA_W-1:0]   read2Stored;

    // ------------------------------------------------------------------
    // Write decoder: one-hot enable per register.
    // ------------------------------------------------------------------
    always_comb begin
        wordEn = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wordEn[i] = bus.writeEn && (bus.writeRegSel == ADDR_W'(i));
        end
    end

    // ------------------------------------------------------------------
    // Register storage.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REGS; g++) begin : genWord
        rf_word #(
            .DATA_W (DATA_W)
        ) uWord (
            .clk     (clk),
            .rst     (rst),
            .inData  (bus.writeData),
            .writeEn (wordEn[g]),
            .outData (wordQ[g])
        );
    end

    // ------------------------------------------------------------------
    // Read muxes (NUM_REGS:1 each).
    // ------------------------------------------------------------------
    always_comb begin
        read1Stored = '0;
        read2Stored = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bus.read1RegSel == ADDR_W'(i)) begin
                read1Stored = wordQ[i];
            end
            if (bus.read2RegSel == ADDR_W'(i)) begin
                read2Stored = wordQ[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output selection, with optional write-to-read bypass.
    // ------------------------------------------------------------------
`ifdef RF_BYPASS_EN
    logic bypass1;
    logic bypass2;

    // Gating with rst keeps outputs at the reset value even if a write is
    // being presented while the array is held in reset.
    always_comb begin
        bypass1 = bus.writeEn && !rst && (bus.writeRegSel == bus.read1RegSel);
        bypass2 = bus.writeEn && !rst && (bus.writeRegSel == bus.read2RegSel);
        bus.read1Data = bypass1 ? bus.writeData : read1Stored;
        bus.read2Data = bypass2 ? bus.writeData : read2Stored;
    end
`else
    always_comb begin
        bus.read1Data = read1Stored;
        bus.read2Data = read2Stored;
    end
`endif

    // ------------------------------------------------------------------
    // X/Z detection on control inputs. Reduction XOR propagates any unknown
    // bit to X; synthesis sees a constant 0.
    // ------------------------------------------------------------------
    always_comb begin
        bus.err = ((^{bus.writeEn, bus.writeRegSel,
                      bus.read1RegSel, bus.read2RegSel}) === 1'bx);
    end

endmodule
